// File: rtl/batch_dispatcher_if.sv
// Handshake and data bundle between batch_dispatcher, the batch memory and the functional-unit array.
// master = dispatcher side, slave = memory / functional-unit / redirect side.
interface batch_dispatcher_if #(
  parameter int FUNCTIONAL_UNITS = 8,
  parameter int BATCH_WIDTH      = 256,
  parameter int ADDRESS_WIDTH    = 64
);
  logic                                    memReqValid;
  logic                                    memReqReady;
  logic [ADDRESS_WIDTH-1:0]                memReqAddr;
  logic                                    memRspValid;
  logic [FUNCTIONAL_UNITS*BATCH_WIDTH-1:0] memRspData;
  logic                                    redirectValid;
  logic [ADDRESS_WIDTH-1:0]                redirectPc;
  logic [FUNCTIONAL_UNITS-1:0]             dispatchValid;
  logic [FUNCTIONAL_UNITS*BATCH_WIDTH-1:0] dispatchBatch;
  logic                                    endTag;
  logic                                    doneBatches;
  logic [ADDRESS_WIDTH-1:0]                pc;
  logic                                    busy;

  modport master (
    output memReqValid, memReqAddr, dispatchValid, dispatchBatch, endTag, pc, busy,
    input  memReqReady, memRspValid, memRspData, redirectValid, redirectPc, doneBatches
  );

  modport slave (
    input  memReqValid, memReqAddr, dispatchValid, dispatchBatch, endTag, pc, busy,
    output memReqReady, memRspValid, memRspData, redirectValid, redirectPc, doneBatches
  );
endinterface

// File: rtl/batch_dispatcher.sv
// Windowed batch fetch + end-bit group dispatch; dispatch one cycle after the response, no input->output paths.
// Fetch stalls on memReqReady and on doneBatches for closed groups; BATCH_DISPATCH_STATS_EN adds stat counters.
module batch_dispatcher #(
  parameter int                       FUNCTIONAL_UNITS = 8,
  parameter int                       BATCH_WIDTH      = 256,
  parameter int                       ADDRESS_WIDTH    = 64,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic               clock,
  input  logic               resetN,
  batch_dispatcher_if.master bus
`ifdef BATCH_DISPATCH_STATS_EN
  ,
  output logic [31:0]        statGroups,
  output logic [31:0]        statWaitCycles,
  output logic [31:0]        statRedirects
`endif
);

  localparam int LANE_W      = $clog2(FUNCTIONAL_UNITS);
  localparam int BATCH_BYTES = BATCH_WIDTH / 8;
  localparam int WINDOW_W    = FUNCTIONAL_UNITS * BATCH_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(BATCH_BYTES - 1);

  typedef enum logic [2:0] {
    S_REQUEST,
    S_WAIT_RSP,
    S_DISPATCH,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [WINDOW_W-1:0]      fetch_buf_q, fetch_buf_d;

  logic                     end_found;
  logic [LANE_W-1:0]        end_lane;
  logic [LANE_W:0]          grp_size;
  logic [ADDRESS_WIDTH-1:0] grp_bytes;
  logic [ADDRESS_WIDTH-1:0] redirect_target;

  // Scan from the top lane down so the lowest set end bit is the one left standing.
  always_comb begin
    end_found = 1'b0;
    end_lane  = '0;
    for (int i = FUNCTIONAL_UNITS - 1; i >= 0; i--) begin
      if (fetch_buf_q[i*BATCH_WIDTH]) begin
        end_found = 1'b1;
        end_lane  = LANE_W'(i);
      end
    end
  end

  assign grp_size        = end_found ? ({1'b0, end_lane} + (LANE_W+1)'(1))
                                     : (LANE_W+1)'(FUNCTIONAL_UNITS);
  assign grp_bytes       = ADDRESS_WIDTH'(grp_size) * ADDRESS_WIDTH'(BATCH_BYTES);
  assign redirect_target = bus.redirectPc & ~OFFSET_MASK;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_buf_d = fetch_buf_q;
    case (state_q)
      S_REQUEST: begin
        if (bus.memReqReady) begin
          state_d = bus.redirectValid ? S_DRAIN : S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus.memRspValid) begin
          if (bus.redirectValid) begin
            state_d = S_REQUEST;
          end else begin
            fetch_buf_d = bus.memRspData;
            state_d     = S_DISPATCH;
          end
        end else if (bus.redirectValid) begin
          state_d = S_DRAIN;
        end
      end
      S_DISPATCH: begin
        pc_d    = pc_q + grp_bytes;
        state_d = end_found ? S_WAIT_DONE : S_REQUEST;
      end
      S_WAIT_DONE: begin
        if (bus.doneBatches) begin
          state_d = S_REQUEST;
        end
      end
      S_DRAIN: begin
        if (bus.memRspValid) begin
          state_d = S_REQUEST;
        end
      end
      default: state_d = S_REQUEST;
    endcase
    if (bus.redirectValid) begin
      pc_d = redirect_target;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_REQUEST;
      pc_q        <= RESET_PC;
      fetch_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_buf_q <= fetch_buf_d;
    end
  end

  always_comb begin
    bus.dispatchValid = '0;
    for (int i = 0; i < FUNCTIONAL_UNITS; i++) begin
      bus.dispatchValid[i] = (state_q == S_DISPATCH) && ((LANE_W+1)'(i) < grp_size);
    end
  end

  assign bus.memReqValid   = (state_q == S_REQUEST);
  assign bus.memReqAddr    = pc_q;
  assign bus.pc            = pc_q;
  assign bus.busy          = (state_q != S_REQUEST);
  assign bus.endTag        = (state_q == S_DISPATCH) && end_found;
  assign bus.dispatchBatch = fetch_buf_q;

`ifdef BATCH_DISPATCH_STATS_EN
  logic [31:0] stat_groups_q, stat_wait_q, stat_redirects_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stat_groups_q    <= '0;
      stat_wait_q      <= '0;
      stat_redirects_q <= '0;
    end else begin
      if ((state_q == S_DISPATCH) && end_found) stat_groups_q <= stat_groups_q + 32'd1;
      if (state_q == S_WAIT_DONE)               stat_wait_q   <= stat_wait_q + 32'd1;
      if (bus.redirectValid)                    stat_redirects_q <= stat_redirects_q + 32'd1;
    end
  end

  assign statGroups     = stat_groups_q;
  assign statWaitCycles = stat_wait_q;
  assign statRedirects  = stat_redirects_q;
`endif

endmodule

// File: tb/tb_batch_dispatcher.sv
// Directed bench for batch_dispatcher: transaction-level model of pc/window/group, per-cycle output compare
// plus hand-computed literal expectations for each scenario.
module tb_batch_dispatcher;
  localparam int FU = 8;
  localparam int BW = 256;
  localparam int AW = 64;
  localparam int W  = FU * BW;
  localparam int BB = BW / 8;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clock;
  logic resetN;

  batch_dispatcher_if #(.FUNCTIONAL_UNITS(FU), .BATCH_WIDTH(BW), .ADDRESS_WIDTH(AW)) bif ();

`ifdef BATCH_DISPATCH_STATS_EN
  logic [31:0] statGroups, statWaitCycles, statRedirects;
`endif

  batch_dispatcher #(
    .FUNCTIONAL_UNITS(FU), .BATCH_WIDTH(BW), .ADDRESS_WIDTH(AW), .RESET_PC(RESET_PC)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bif)
`ifdef BATCH_DISPATCH_STATS_EN
    ,
    .statGroups     (statGroups),
    .statWaitCycles (statWaitCycles),
    .statRedirects  (statRedirects)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model state and the outputs expected in the current cycle.
  logic [AW-1:0] m_pc;
  logic [W-1:0]  m_buf;
  bit            chk_en = 1'b0;
  logic          e_req, e_busy, e_end;
  logic [FU-1:0] e_dv;
  logic [AW-1:0] e_pc;
  logic [W-1:0]  e_buf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_set(input logic req, input logic bsy, input logic [FU-1:0] dv, input logic et);
    e_req  = req;
    e_busy = bsy;
    e_dv   = dv;
    e_end  = et;
    e_pc   = m_pc;
    e_buf  = m_buf;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("memReqValid", 64'(bif.memReqValid), 64'(e_req));
      chk("memReqAddr", bif.memReqAddr, e_pc);
      chk("pc", bif.pc, e_pc);
      chk("busy", 64'(bif.busy), 64'(e_busy));
      chk("dispatchValid", 64'(bif.dispatchValid), 64'(e_dv));
      chk("endTag", 64'(bif.endTag), 64'(e_end));
      checks++;
      if (bif.dispatchBatch !== e_buf) begin
        failures++;
        $display("FAIL dispatchBatch actual_lo=0x%0h expected_lo=0x%0h at %0t",
                 bif.dispatchBatch[63:0], e_buf[63:0], $time);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [FU-1:0] ends, input int seed);
    logic [W-1:0]  d;
    logic [BW-1:0] b;
    d = '0;
    for (int i = 0; i < FU; i++) begin
      b = {8{32'hC0DE_0000 + 32'(seed * 16 + i)}};
      b[0] = ends[i];
      d[i*BW +: BW] = b;
    end
    return d;
  endfunction

  // Lowest lane carrying an end bit, -1 for an open window.
  function automatic int first_end(input logic [W-1:0] d);
    for (int i = 0; i < FU; i++) begin
      if (d[i*BW]) return i;
    end
    return -1;
  endfunction

  function automatic logic [FU-1:0] lanes(input int g);
    logic [FU-1:0] m;
    m = '0;
    for (int i = 0; i < g; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(BB - 1);
  endfunction

  // Starts and ends in a REQUEST cycle.
  task automatic fetch_dispatch(input logic [W-1:0] d, input int stall, input int lat,
                                input int done_wait, input bit stray_done,
                                input logic [FU-1:0] lit_dv, input logic lit_end,
                                input logic [AW-1:0] lit_pc);
    int k;
    int g;
    for (int c = 0; c < stall; c++) begin
      exp_set(1'b1, 1'b0, '0, 1'b0);
      step();
    end
    exp_set(1'b1, 1'b0, '0, 1'b0);
    bif.memReqReady = 1'b1;
    step();
    bif.memReqReady = 1'b0;
    for (int c = 0; c < lat; c++) begin
      exp_set(1'b0, 1'b1, '0, 1'b0);
      bif.doneBatches = stray_done;
      if (c == lat - 1) begin
        bif.memRspValid = 1'b1;
        bif.memRspData  = d;
      end
      step();
      bif.memRspValid = 1'b0;
      bif.doneBatches = 1'b0;
    end
    m_buf = d;
    k = first_end(d);
    g = (k < 0) ? FU : k + 1;
    exp_set(1'b0, 1'b1, lanes(g), k >= 0);
    #2;
    chk("lit_dispatchValid", 64'(bif.dispatchValid), 64'(lit_dv));
    chk("lit_endTag", 64'(bif.endTag), 64'(lit_end));
    step();
    m_pc = m_pc + AW'(g * BB);
    if (k >= 0) begin
      for (int c = 0; c <= done_wait; c++) begin
        exp_set(1'b0, 1'b1, '0, 1'b0);
        if (c == done_wait) bif.doneBatches = 1'b1;
        step();
        bif.doneBatches = 1'b0;
      end
    end
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("lit_next_addr", bif.memReqAddr, lit_pc);
    chk("lit_next_req", 64'(bif.memReqValid), 64'd1);
  endtask

  task automatic redirect_idle(input logic [AW-1:0] tgt, input logic [AW-1:0] lit);
    exp_set(1'b1, 1'b0, '0, 1'b0);
    bif.redirectValid = 1'b1;
    bif.redirectPc    = tgt;
    step();
    bif.redirectValid = 1'b0;
    m_pc = align(tgt);
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("lit_redirect_idle_addr", bif.memReqAddr, lit);
  endtask

  // mode 0: redirect in WAIT_RSP alone; 1: with the response; 2: in REQUEST with ready.
  task automatic redirect_fetch(input int mode, input logic [AW-1:0] tgt, input logic [AW-1:0] lit);
    exp_set(1'b1, 1'b0, '0, 1'b0);
    bif.memReqReady = 1'b1;
    if (mode == 2) begin
      bif.redirectValid = 1'b1;
      bif.redirectPc    = tgt;
    end
    step();
    bif.memReqReady   = 1'b0;
    bif.redirectValid = 1'b0;
    if (mode == 2) m_pc = align(tgt);
    if (mode != 2) begin
      exp_set(1'b0, 1'b1, '0, 1'b0);
      bif.redirectValid = 1'b1;
      bif.redirectPc    = tgt;
      if (mode == 1) begin
        bif.memRspValid = 1'b1;
        bif.memRspData  = mk(8'h01, 40 + mode);
      end
      step();
      bif.redirectValid = 1'b0;
      bif.memRspValid   = 1'b0;
      m_pc = align(tgt);
    end
    if (mode != 1) begin
      exp_set(1'b0, 1'b1, '0, 1'b0);
      #2;
      chk("lit_redirect_pc", bif.pc, lit);
      step();
      exp_set(1'b0, 1'b1, '0, 1'b0);
      bif.memRspValid = 1'b1;
      bif.memRspData  = mk(8'hFF, 50 + mode);
      step();
      bif.memRspValid = 1'b0;
    end
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("lit_redirect_next_addr", bif.memReqAddr, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN            = 1'b0;
    bif.memReqReady   = 1'b0;
    bif.memRspValid   = 1'b0;
    bif.memRspData    = '0;
    bif.redirectValid = 1'b0;
    bif.redirectPc    = '0;
    bif.doneBatches   = 1'b0;
    m_pc  = RESET_PC;
    m_buf = '0;
    exp_set(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    #2;
    chk("lit_reset_req", 64'(bif.memReqValid), 64'd1);
    chk("lit_reset_busy", 64'(bif.busy), 64'd0);
    chk("lit_reset_pc", bif.pc, 64'd0);
    step();
    step();
    resetN = 1'b1;

    // Closed group: lanes 0..2, pc 0 -> 0x60, fetch held until doneBatches.
    fetch_dispatch(mk(8'b0000_0100, 1), 0, 2, 3, 1'b0, 8'b0000_0111, 1'b1, 64'h60);
    redirect_idle(64'h1F, 64'h0);
    // Open group: full window, pc 0 -> 0x100, request right after dispatch.
    fetch_dispatch(mk(8'b0000_0000, 2), 2, 3, 0, 1'b0, 8'hFF, 1'b0, 64'h100);
    fetch_dispatch(mk(8'b1000_0000, 3), 0, 1, 0, 1'b0, 8'hFF, 1'b1, 64'h200);
    fetch_dispatch(mk(8'b0000_0000, 4), 0, 1, 0, 1'b0, 8'hFF, 1'b0, 64'h300);
    fetch_dispatch(mk(8'b0000_0000, 5), 0, 1, 0, 1'b0, 8'hFF, 1'b0, 64'h400);
    // Wrap: single-batch group at the top of the address space; stray doneBatches ignored.
    redirect_idle(64'hFFFF_FFFF_FFFF_FFE7, 64'hFFFF_FFFF_FFFF_FFE0);
    fetch_dispatch(mk(8'b0000_0101, 6), 0, 2, 1, 1'b1, 8'h01, 1'b1, 64'h0);
    redirect_fetch(0, 64'h1013, 64'h1000);
    redirect_fetch(1, 64'h2ABC, 64'h2AA0);
    redirect_fetch(2, 64'h40, 64'h40);

    // Reset during WAIT_RSP at pc 0x40.
    exp_set(1'b1, 1'b0, '0, 1'b0);
    bif.memReqReady = 1'b1;
    step();
    bif.memReqReady = 1'b0;
    exp_set(1'b0, 1'b1, '0, 1'b0);
    #1;
    resetN = 1'b0;
    m_pc  = RESET_PC;
    m_buf = '0;
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("lit_midreset_req", 64'(bif.memReqValid), 64'd1);
    chk("lit_midreset_busy", 64'(bif.busy), 64'd0);
    chk("lit_midreset_pc", bif.pc, 64'd0);
    chk("lit_midreset_batch_lo", bif.dispatchBatch[63:0], 64'd0);
    step();
    resetN = 1'b1;
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("lit_postreset_addr", bif.memReqAddr, 64'd0);
    step();
    exp_set(1'b1, 1'b0, '0, 1'b0);
    bif.memRspValid = 1'b1;
    bif.memRspData  = mk(8'hFF, 7);
    step();
    bif.memRspValid = 1'b0;
    exp_set(1'b1, 1'b0, '0, 1'b0);
    #2;
    chk("lit_late_rsp_dv", 64'(bif.dispatchValid), 64'd0);
    chk("lit_late_rsp_busy", 64'(bif.busy), 64'd0);

    // Two closed groups with five WAIT_DONE cycles each, then one redirect.
    fetch_dispatch(mk(8'b0000_0010, 8), 0, 1, 4, 1'b0, 8'b0000_0011, 1'b1, 64'h40);
    fetch_dispatch(mk(8'b0001_0000, 9), 0, 2, 4, 1'b0, 8'b0001_1111, 1'b1, 64'hE0);
    redirect_idle(64'h305, 64'h300);
`ifdef BATCH_DISPATCH_STATS_EN
    chk("lit_statGroups", 64'(statGroups), 64'd2);
    chk("lit_statWaitCycles", 64'(statWaitCycles), 64'd10);
    chk("lit_statRedirects", 64'(statRedirects), 64'd1);
`endif
    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
